mem_port_ctrl: RTL and testbench

Load/store controller that drives one word-wide single-port synchronous RAM (`lpm_ram_dq`, 32-bit data, registered read) on behalf of the CPU's memory stage. It accepts byte, halfword and word requests at byte addresses and returns sign- or zero-extended load data. It performs read-modify-write for sub-word stores, because the RAM has no byte enables. It sits between the execute/memory stage and the data-memory `lpm_ram_dq` instance.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/mem_lane_align.sv | 55 +++++
 rtl/mem_port_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_port_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and helpers for the data-memory load/store port
package mem_pkg;

    localparam int MEM_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_DATA,
        ST_WR,
        ST_RESP
    } mem_state_e;

    // Size 2'b11 has no legal encoding, so it always faults.
    function automatic logic mem_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic fault;
        case (size)
            MEM_BYTE: fault = 1'b0;
            MEM_HALF: fault = addr_lo[0];
            MEM_WORD: fault = |addr_lo;
            default:  fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian lane extract/extend for loads and lane merge for sub-word stores
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]                size_i,
    input  logic [1:0]                addr_lo_i,
    input  logic                      unsigned_i,
    input  logic [MEM_DATA_WIDTH-1:0] word_i,
    input  logic [15:0]               wdata_i,
    output logic [MEM_DATA_WIDTH-1:0] load_o,
    output logic [MEM_DATA_WIDTH-1:0] store_o
);

    logic [4:0]  byte_lsb;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign_bit;

    assign byte_lsb = {addr_lo_i, 3'b000};
    assign byte_sel = word_i[byte_lsb +: 8];
    assign half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        load_o   = word_i;
        sign_bit = 1'b0;
        case (size_i)
            MEM_BYTE: begin
                sign_bit = byte_sel[7] & ~unsigned_i;
                load_o   = {{24{sign_bit}}, byte_sel};
            end
            MEM_HALF: begin
                sign_bit = half_sel[15] & ~unsigned_i;
                load_o   = {{16{sign_bit}}, half_sel};
            end
            default: load_o = word_i;
        endcase
    end

    // Word stores bypass the merge, so only byte and half lanes are replaced here.
    always_comb begin
        store_o = word_i;
        case (size_i)
            MEM_BYTE: store_o[byte_lsb +: 8] = wdata_i[7:0];
            MEM_HALF: begin
                if (addr_lo_i[1]) begin
                    store_o[31:16] = wdata_i;
                end else begin
                    store_o[15:0] = wdata_i;
                end
            end
            default: store_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_port_ctrl.sv
// rtl/mem_port_ctrl.sv - load/store controller for a word-wide single-port RAM with registered read
module mem_port_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [1:0]                req_size,
    input  logic                      req_unsigned,
    input  logic [31:0]               req_addr,
    input  logic [MEM_DATA_WIDTH-1:0] req_wdata,
    output logic                      resp_valid,
    output logic [MEM_DATA_WIDTH-1:0] resp_rdata,
    output logic                      resp_misaligned,
    output logic [ADDR_WIDTH-1:0]     ram_address,
    output logic [MEM_DATA_WIDTH-1:0] ram_data,
    output logic                      ram_we,
    input  logic [MEM_DATA_WIDTH-1:0] ram_q
);

    mem_state_e                state_q, state_d;
    logic                      write_q, write_d;
    logic [1:0]                size_q, size_d;
    logic                      unsigned_q, unsigned_d;
    logic [ADDR_WIDTH+1:0]     addr_q, addr_d;
    logic [MEM_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [MEM_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      mis_q, mis_d;

    logic                      accept;
    logic                      fault;
    logic [MEM_DATA_WIDTH-1:0] load_data;
    logic [MEM_DATA_WIDTH-1:0] store_data;
    logic                      unused_addr_hi;

    // Bytes above the RAM's reach are dropped, so addresses wrap.
    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

    assign req_ready       = (state_q == ST_IDLE) && !rst;
    assign accept          = req_valid && req_ready;
    assign fault           = mem_misaligned(req_size, req_addr[1:0]);
    assign ram_address     = addr_q[ADDR_WIDTH+1:2];
    assign resp_rdata      = rdata_q;
    assign resp_misaligned = mis_q;

    mem_lane_align u_lane_align (
        .size_i     (size_q),
        .addr_lo_i  (addr_q[1:0]),
        .unsigned_i (unsigned_q),
        .word_i     (ram_q),
        .wdata_i    (wdata_q[15:0]),
        .load_o     (load_data),
        .store_o    (store_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            mis_q      <= mis_d;
        end
    end

    // ram_we is a pure state decode so an async reset withdraws it before the next edge.
    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        mis_d      = mis_q;
        ram_we     = 1'b0;
        ram_data   = '0;
        resp_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    write_d    = req_write;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    addr_d     = req_addr[ADDR_WIDTH+1:0];
                    wdata_d    = req_wdata;
                    rdata_d    = '0;
                    mis_d      = fault;
                    if (fault) begin
                        state_d = ST_RESP;
                    end else if (req_write && (req_size == MEM_WORD)) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (write_q) begin
                    ram_we   = 1'b1;
                    ram_data = store_data;
                end else begin
                    rdata_d = load_data;
                end
                state_d = ST_RESP;
            end
            ST_WR: begin
                ram_we   = 1'b1;
                ram_data = wdata_q;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb/tb_mem_port_ctrl.sv - scoreboard bench for mem_port_ctrl against a registered-read RAM model
module tb_mem_port_ctrl;

    localparam int AW = 8;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_unsigned = 1'b0;
    logic [31:0]   req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_misaligned;
    logic [AW-1:0] ram_address;
    logic [31:0]   ram_data;
    logic          ram_we;
    logic [31:0]   ram_q;

    always #5 clk = ~clk;

    mem_port_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .ram_address     (ram_address),
        .ram_data        (ram_data),
        .ram_we          (ram_we),
        .ram_q           (ram_q)
    );

    // RAM model: synchronous write, registered read, plus a backdoor preload port.
    logic [31:0] mem [0:255];
    logic        pl_we = 1'b0;
    logic [7:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (ram_we) mem[ram_address] <= ram_data;
        ram_q <= mem[ram_address];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          lat;
        int          wen;
        int          woff;
        int          acc;
        string       nm;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   we_cnt = 0;
    int   we_cyc = 0;
    int   resp_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (ram_we) begin
                we_cnt++;
                we_cyc = cyc;
            end
            if (resp_valid) begin
                resp_cnt++;
                if (sbq.size() == 0) begin
                    chk("unexpected_resp", resp_valid, 1'b0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk({mon_e.nm, " latency"}, cyc - mon_e.acc, mon_e.lat);
                    chk({mon_e.nm, " rdata"}, resp_rdata, mon_e.rdata);
                    chk({mon_e.nm, " misaligned"}, resp_misaligned, mon_e.mis);
                    chk({mon_e.nm, " we_count"}, we_cnt, mon_e.wen);
                    if (mon_e.wen > 0) chk({mon_e.nm, " we_cycle"}, we_cyc - mon_e.acc, mon_e.woff);
                end
                we_cnt = 0;
            end
        end
    end

    task automatic issue(input string nm, input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] er,
                         input logic em, input int lat, input int wen, input int woff);
        int   n;
        exp_t e;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk({nm, " ready_timeout"}, req_ready, 1'b1);
            return;
        end
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = wd;
        e = '{er, em, lat, wen, woff, cyc, nm};
        sbq.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_wdata = '0;
        n = 0;
        while (sbq.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            chk({nm, " resp_timeout"}, sbq.size(), 0);
            sbq.delete();
        end
    endtask

    int n0;

    initial begin
        pl_we   = 1'b1;
        pl_addr = 8'd4;
        pl_data = 32'h8899AABB;
        @(negedge clk);
        chk("reset req_ready", req_ready, 1'b0);
        chk("reset resp_valid", resp_valid, 1'b0);
        chk("reset resp_rdata", resp_rdata, 32'h0);
        chk("reset resp_misaligned", resp_misaligned, 1'b0);
        chk("reset ram_we", ram_we, 1'b0);
        chk("reset ram_data", ram_data, 32'h0);
        chk("reset ram_address", ram_address, 8'h0);
        @(posedge clk);
        #1 pl_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset req_ready", req_ready, 1'b1);
        we_cnt = 0;

        issue("LB_11",   0, SZ_B, 0, 32'h11,  0, 32'hFFFFFFAA, 0, 3, 0, 0);
        issue("LBU_11",  0, SZ_B, 1, 32'h11,  0, 32'h000000AA, 0, 3, 0, 0);
        issue("LB_10",   0, SZ_B, 0, 32'h10,  0, 32'hFFFFFFBB, 0, 3, 0, 0);
        issue("LH_12",   0, SZ_H, 0, 32'h12,  0, 32'hFFFF8899, 0, 3, 0, 0);
        issue("LHU_10",  0, SZ_H, 1, 32'h10,  0, 32'h0000AABB, 0, 3, 0, 0);
        issue("LBU_413", 0, SZ_B, 1, 32'h413, 0, 32'h00000088, 0, 3, 0, 0);
        issue("SB_12",   1, SZ_B, 0, 32'h12,  32'h0000005C, 32'h0, 0, 3, 1, 2);
        issue("LW_10_a", 0, SZ_W, 0, 32'h10,  0, 32'h885CAABB, 0, 3, 0, 0);
        issue("SH_12",   1, SZ_H, 0, 32'h12,  32'hFFFF1234, 32'h0, 0, 3, 1, 2);
        issue("LHU_12",  0, SZ_H, 1, 32'h12,  0, 32'h00001234, 0, 3, 0, 0);
        issue("LW_10_b", 0, SZ_W, 0, 32'h10,  0, 32'h1234AABB, 0, 3, 0, 0);
        issue("LH_13",   0, SZ_H, 0, 32'h13,  0, 32'h0, 1, 1, 0, 0);
        issue("LW_12",   0, SZ_W, 0, 32'h12,  0, 32'h0, 1, 1, 0, 0);
        issue("SW_11",   1, SZ_W, 0, 32'h11,  32'hAAAAAAAA, 32'h0, 1, 1, 0, 0);
        issue("SZ3_10",  0, SZ_X, 0, 32'h10,  0, 32'h0, 1, 1, 0, 0);
        issue("LW_10_c", 0, SZ_W, 0, 32'h10,  0, 32'h1234AABB, 0, 3, 0, 0);
        issue("SW_400",  1, SZ_W, 0, 32'h400, 32'hDEADBEEF, 32'h0, 0, 2, 1, 1);
        issue("LW_000",  0, SZ_W, 0, 32'h0,   0, 32'hDEADBEEF, 0, 3, 0, 0);
        issue("LB_13",   0, SZ_B, 0, 32'h13,  0, 32'h00000012, 0, 3, 0, 0);
        issue("SB_13",   1, SZ_B, 0, 32'h13,  32'h12345680, 32'h0, 0, 3, 1, 2);
        issue("LB_13b",  0, SZ_B, 0, 32'h13,  0, 32'hFFFFFF80, 0, 3, 0, 0);
        issue("LH_12b",  0, SZ_H, 0, 32'h12,  0, 32'hFFFF8034, 0, 3, 0, 0);

        // Reset during RD of a sub-word store.
        @(negedge clk);
        we_cnt       = 0;
        n0           = resp_cnt;
        req_valid    = 1'b1;
        req_write    = 1'b1;
        req_size     = SZ_B;
        req_unsigned = 1'b0;
        req_addr     = 32'h10;
        req_wdata    = 32'h0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        chk("abort_rd req_ready", req_ready, 1'b0);
        chk("abort_rd ram_we", ram_we, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_rd no_we", we_cnt, 0);
        chk("abort_rd no_resp", resp_cnt - n0, 0);
        issue("LW_10_d", 0, SZ_W, 0, 32'h10, 0, 32'h8034AABB, 0, 3, 0, 0);

        // Reset during WR of a word store.
        @(negedge clk);
        we_cnt       = 0;
        n0           = resp_cnt;
        req_valid    = 1'b1;
        req_write    = 1'b1;
        req_size     = SZ_W;
        req_addr     = 32'h10;
        req_wdata    = 32'h55555555;
        @(posedge clk);
        #1 rst = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort_wr ram_we", ram_we, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_wr no_we", we_cnt, 0);
        chk("abort_wr no_resp", resp_cnt - n0, 0);
        issue("LW_10_e", 0, SZ_W, 0, 32'h10, 0, 32'h8034AABB, 0, 3, 0, 0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
